// File: rtl/uart_pkg.sv
// Shared UART definitions: default divisor widths, minimum divisor and the
// baud configuration record used by the baud generator and the register block.
package uart_pkg;

    localparam int unsigned DIV_W_DEF  = 16;
    localparam int unsigned FRAC_W_DEF = 4;
    localparam int unsigned MIN_DIV    = 2;

    typedef struct packed {
        logic [DIV_W_DEF-1:0]  div;
        logic [FRAC_W_DEF-1:0] frac;
    } baud_cfg_t;

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator for baud_tick_gen; built only when BAUD_FRAC_EN
// is defined. carry stretches the current period by one cycle.
`ifdef BAUD_FRAC_EN
module baud_frac_acc
    import uart_pkg::*;
#(
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [FRAC_W-1:0] frac,
    input  logic              wrap,
    input  logic              clear,
    output logic              carry
);

    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;

    assign sum   = {1'b0, acc} + {1'b0, frac};
    assign carry = sum[FRAC_W];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (wrap) begin
            acc <= sum[FRAC_W-1:0];
        end
    end

endmodule
`endif

// File: rtl/baud_tick_gen.sv
// Programmable oversampling baud tick generator with handshaked divisor load
// and start-edge resync. Define BAUD_FRAC_EN to build the fractional accumulator.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned       DIV_W      = DIV_W_DEF,
    parameter int unsigned       FRAC_W     = FRAC_W_DEF,
    parameter int unsigned       OVERSAMPLE = 8,
    parameter logic [DIV_W-1:0]  RESET_DIV  = DIV_W'(130),
    parameter logic [FRAC_W-1:0] RESET_FRAC = FRAC_W'(3)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [DIV_W-1:0]              i_div,
    input  logic [FRAC_W-1:0]             i_frac,
    input  logic                          i_cfg_valid,
    output logic                          o_cfg_ready,
    input  logic                          i_resync,
    output logic                          o_os_tick,
    output logic                          o_bit_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] o_phase
);

    localparam int unsigned     PH_W    = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2);

    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_last;
    logic [PH_W-1:0]  phase;
    logic             pend;
    logic             carry;
    logic             accept;
    logic             apply;
    logic             wrap;
    logic             clear;
    logic             os_tick;
    logic             bit_tick;

    assign accept   = i_cfg_valid && !pend;
    // div_act is never below MIN_DIV, so the subtraction cannot underflow
    assign cnt_last = div_act - DIV_W'(1) + DIV_W'(carry);
    assign wrap     = i_enable && !i_resync && (cnt == cnt_last);
    assign clear    = !i_enable || i_resync;
    assign apply    = pend && (wrap || clear);

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_act;
    logic [FRAC_W-1:0] frac_pend;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            frac_act <= RESET_FRAC;
        end else if (apply) begin
            frac_act <= frac_pend;
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            frac_pend <= i_frac;
        end
    end

    baud_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .frac   (frac_act),
        .wrap   (wrap),
        .clear  (clear),
        .carry  (carry)
    );
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^{i_frac, RESET_FRAC};
`endif

    always_ff @(posedge i_clk) begin
        if (accept) begin
            div_pend <= (i_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : i_div;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt      <= '0;
            phase    <= '0;
            os_tick  <= 1'b0;
            bit_tick <= 1'b0;
            pend     <= 1'b0;
            div_act  <= RESET_DIV;
        end else begin
            os_tick  <= wrap;
            bit_tick <= wrap && (phase == PH_LAST);
            // resync outranks a coincident wrap
            if (!i_enable) begin
                cnt   <= '0;
                phase <= '0;
            end else if (i_resync) begin
                cnt   <= '0;
                phase <= PH_MID;
            end else if (wrap) begin
                cnt   <= '0;
                phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            end else begin
                cnt   <= cnt + DIV_W'(1);
            end
            if (accept) begin
                pend <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
            if (apply) begin
                div_act <= div_pend;
            end
        end
    end

    assign o_cfg_ready = !pend;
    assign o_os_tick   = os_tick;
    assign o_bit_tick  = bit_tick;
    assign o_phase     = phase;

endmodule
